serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; even, >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port sdi, input, 1 bit: asynchronous serial line from the shift-out transmitter; idles high.
REQ-006 SHALL have port data_out, output, DATA_BITS bits: last good frame payload.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when a frame with a good stop bit is accepted.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port parity_err, output, 1 bit: one-cycle pulse, coincident with valid, on a parity mismatch.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL pass sdi through a 2-flop synchronizer; all decisions use the second flop (sdi_s).
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE, using a bit-timer of ceil(log2(CLKS_PER_BIT)) bits and a bit index.
REQ-013 In IDLE, SHALL move to START with the timer at 0 when sdi_s is 0.
REQ-014 In START, SHALL sample sdi_s when the timer reaches CLKS_PER_BIT/2-1; if 0, go to DATA with timer and index at 0; if 1 (glitch), return to IDLE with no flag.
REQ-015 In DATA, SHALL sample sdi_s each time the timer reaches CLKS_PER_BIT-1, then wrap the timer to 0.
REQ-016 DATA SHALL shift bits in LSB first; after the DATA_BITS-th sample it SHALL go to PARITY if PARITY_EN is defined, otherwise to STOP.
REQ-017 In STOP, SHALL sample sdi_s when the timer reaches CLKS_PER_BIT-1.
REQ-018 On a STOP sample of 1: data_out <= shift register, valid = 1 for the next cycle, go to IDLE.
REQ-019 On a STOP sample of 0: frame_err = 1 for the next cycle, data_out unchanged, valid stays 0, go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL go to IDLE on the first cycle sdi_s is 1.
REQ-021 Total latency SHALL be exactly 154 cycles at the default parameters: the sdi falling edge is first sampled on edge 0, and valid/frame_err go high after edge 2+CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT (+CLKS_PER_BIT with parity).
REQ-022 Because the STOP sample is taken mid-bit, back-to-back frames with no idle gap SHALL be received without loss.
REQ-023 data_out SHALL hold its value between accepted frames; valid, frame_err and parity_err SHALL never be high simultaneously except parity_err with valid.

Reset
REQ-024 When clr is high at a rising clk edge: state=IDLE, timer=0, index=0, shift register=0, data_out=0, valid=0, frame_err=0, parity_err=0, busy=0, synchronizer flops=1.
REQ-025 clr mid-frame SHALL abort the frame with no valid or error pulse; reception SHALL resume on the first falling edge after clr deasserts.

Configuration
REQ-026 Macro SERIAL_FRAME_RX_PARITY_EN, when defined, SHALL compile in the PARITY state: one even-parity bit after the data, sampled like a data bit.
REQ-027 With SERIAL_FRAME_RX_PARITY_EN defined, a parity mismatch SHALL still update data_out and pulse valid, and SHALL also pulse parity_err.
REQ-028 With SERIAL_FRAME_RX_PARITY_EN undefined, there SHALL be no PARITY state and parity_err SHALL be tied to 0.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, macro undefined unless stated)
REQ-029 Frame 0xA5 with stop bit 1 -> single valid pulse exactly 154 cycles after the falling edge, data_out=0xA5, busy low afterward.
REQ-030 sdi low for 3 cycles, then high -> returns to IDLE, no valid, no frame_err, busy high for at most 10 cycles.
REQ-031 After 0xA5, frame 0x5A with stop bit 0 -> frame_err pulse, data_out stays 0xA5; while sdi is held low, busy stays high; once sdi goes high, busy returns low.
REQ-032 Back-to-back frames 0x00 then 0xFF, no gap -> two valid pulses 160 cycles apart, data_out=0x00 then 0xFF.
REQ-033 clr pulsed during data bit 4 -> busy=0 next cycle, no pulse; next frame 0x3C received correctly.
REQ-034 Macro defined: 0x07 with parity bit 0 -> valid and parity_err pulse together, data_out=0x07; 0x07 with parity bit 1 -> valid only.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial frame receiver signal bundle
//
// Groups the serial line and the receiver outputs.
//   sdi        : serial line into the receiver (idles high)
//   data_out   : last good frame payload
//   valid      : one-cycle pulse on an accepted frame
//   frame_err  : one-cycle pulse on a low stop bit
//   parity_err : one-cycle pulse with valid on a parity mismatch
//   busy       : receiver is not idle
// Modports: master drives sdi and observes the outputs; slave is the receiver.
interface serial_frame_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 sdi;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output sdi,
        input  data_out,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  sdi,
        output data_out,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - oversampling serial frame receiver
//
// Receives start bit, DATA_BITS data bits (LSB first), optional even parity
// bit and one stop bit from a line sampled CLKS_PER_BIT times per bit.
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN (adds the parity bit).
// Ports:
//   clk : clock, rising edge
//   clr : synchronous active-high reset
//   bus : serial_frame_rx_if.slave (sdi in; data_out, valid, frame_err,
//         parity_err, busy out)
module serial_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                clk,
    input  logic                clr,
    serial_frame_rx_if.slave    bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_T   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_T   = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef SERIAL_FRAME_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // Two-flop synchronizer; both flops reset to the idle (high) level.
    logic sync1_q;
    logic sdi_s;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b1;
            sdi_s   <= 1'b1;
        end else begin
            sync1_q <= bus.sdi;
            sdi_s   <= sync1_q;
        end
    end

    state_t               state_q,  state_d;
    logic [TW-1:0]        timer_q,  timer_d;
    logic [IW-1:0]        idx_q,    idx_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 valid_q,  valid_d;
    logic                 ferr_q,   ferr_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic                 pbad_q,   pbad_d;   // parity mismatch seen in this frame
    logic                 perr_q,   perr_d;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                idx_d   = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                pbad_d  = 1'b0;
`endif
                if (!sdi_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (timer_q == HALF_T) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = sdi_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (timer_q == FULL_T) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    shift_d[DATA_BITS-1] = sdi_s;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

`ifdef SERIAL_FRAME_RX_PARITY_EN
            S_PARITY: begin
                // Even parity: data ones plus parity bit must be even.
                if (timer_q == FULL_T) begin
                    timer_d = '0;
                    pbad_d  = sdi_s ^ (^shift_q);
                    state_d = S_STOP;
                end
            end
`endif

            S_STOP: begin
                // Sampled mid-bit, so the next start edge is never missed.
                if (timer_q == FULL_T) begin
                    timer_d = '0;
                    if (sdi_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        perr_d  = pbad_q;
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // A held-low line after a bad stop bit is a break, not a start.
                timer_d = '0;
                if (sdi_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                timer_d = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != S_IDLE);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx
module tb_serial_frame_rx;
    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // Edge-0 to result edge, from the frame timing rules.
    localparam int LAT    = 2 + CPB / 2 + (DB + 1) * CPB + (PAR ? CPB : 0);
    localparam int FRAME  = (DB + 2 + (PAR ? 1 : 0)) * CPB;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    serial_frame_rx_if #(.DATA_BITS(DB)) bus ();

    serial_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [DB-1:0] last_good;

    always @(posedge clk) cyc <= cyc + 1;

    int            v_cyc[$];
    logic [DB-1:0] v_data[$];
    bit            v_perr[$];
    int            f_cyc[$];
    logic [DB-1:0] f_data[$];

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_data.push_back(bus.data_out);
            v_perr.push_back(bus.parity_err);
        end
        if (bus.frame_err === 1'b1) begin
            f_cyc.push_back(cyc);
            f_data.push_back(bus.data_out);
        end
        if (bus.valid === 1'b1 || bus.frame_err === 1'b1 || bus.parity_err === 1'b1) begin
            checks++;
            if ((bus.valid === 1'b1 && bus.frame_err === 1'b1) ||
                (bus.parity_err === 1'b1 && bus.valid !== 1'b1)) begin
                errors++;
                $display("FAIL pulse_exclusive: valid=%b frame_err=%b parity_err=%b at cyc %0d, required no overlap other than parity_err with valid",
                         bus.valid, bus.frame_err, bus.parity_err, cyc);
            end
        end
    end

    task automatic clear_q();
        v_cyc.delete(); v_data.delete(); v_perr.delete();
        f_cyc.delete(); f_data.delete();
    endtask

    task automatic drive_bit(input logic b);
        bus.sdi = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.sdi = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic pbit,
                              input logic stop, output int fall);
        fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PAR) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
        checks++;
        if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        clr = 1'b0;
        idle(5);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        int fall;
        clear_q();
        send_frame(8'hA5, ^8'hA5, 1'b1, fall);
        idle(2 * CPB);
        last_good = 8'hA5;
        checks++;
        if (v_cyc.size() != 1) begin errors++; $display("FAIL single_count: got %0d valid pulses want 1", v_cyc.size()); end
        else begin
            checks++;
            if (v_cyc[0] != fall + 1 + LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", v_cyc[0] - fall - 1, LAT); end
            checks++;
            if (v_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", v_data[0]); end
        end
        checks++;
        if (f_cyc.size() != 0) begin errors++; $display("FAIL single_ferr: got %0d frame_err pulses want 0", f_cyc.size()); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_glitch();
        int bc = 0;
        clear_q();
        bus.sdi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.sdi = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (bus.busy === 1'b1) bc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bc < 1 || bc > 10) begin errors++; $display("FAIL glitch_busy_cycles: got %0d want 1..10", bc); end
        checks++;
        if (v_cyc.size() != 0 || f_cyc.size() != 0) begin
            errors++; $display("FAIL glitch_pulses: got valid=%0d frame_err=%0d want 0 0", v_cyc.size(), f_cyc.size());
        end
    endtask

    task automatic test_frame_err();
        int fall;
        clear_q();
        send_frame(8'h5A, ^8'h5A, 1'b0, fall);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %b want 1", bus.busy); end
        checks++;
        if (f_cyc.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", f_cyc.size()); end
        else begin
            checks++;
            if (f_cyc[0] != fall + 1 + LAT) begin errors++; $display("FAIL ferr_latency: got %0d want %0d", f_cyc[0] - fall - 1, LAT); end
        end
        checks++;
        if (v_cyc.size() != 0) begin errors++; $display("FAIL ferr_valid: got %0d valid pulses want 0", v_cyc.size()); end
        checks++;
        if (bus.data_out !== last_good) begin errors++; $display("FAIL ferr_data_hold: got %h want %h", bus.data_out, last_good); end
        idle(4);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", bus.busy); end
        idle(CPB);
    endtask

    task automatic test_back_to_back();
        int f0, f1;
        clear_q();
        send_frame(8'h00, 1'b0, 1'b1, f0);
        send_frame(8'hFF, 1'b0, 1'b1, f1);
        idle(2 * CPB);
        last_good = 8'hFF;
        checks++;
        if (v_cyc.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", v_cyc.size()); end
        else begin
            checks++;
            if (v_cyc[1] - v_cyc[0] != FRAME) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", v_cyc[1] - v_cyc[0], FRAME); end
            checks++;
            if (v_data[0] !== 8'h00 || v_data[1] !== 8'hFF) begin
                errors++; $display("FAIL b2b_data: got %h %h want 00 ff", v_data[0], v_data[1]);
            end
            checks++;
            if (v_cyc[0] != f0 + 1 + LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", v_cyc[0] - f0 - 1, LAT); end
        end
    endtask

    task automatic test_clr_abort();
        int fall;
        clear_q();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        bus.sdi = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.data_out !== '0) begin errors++; $display("FAIL clr_data_out: got %h want 0", bus.data_out); end
        idle(2 * CPB);
        checks++;
        if (v_cyc.size() != 0 || f_cyc.size() != 0) begin
            errors++; $display("FAIL clr_pulses: got valid=%0d frame_err=%0d want 0 0", v_cyc.size(), f_cyc.size());
        end
        clear_q();
        send_frame(8'h3C, ^8'h3C, 1'b1, fall);
        idle(2 * CPB);
        last_good = 8'h3C;
        checks++;
        if (v_cyc.size() != 1) begin errors++; $display("FAIL clr_resume_count: got %0d want 1", v_cyc.size()); end
        else begin
            checks++;
            if (v_data[0] !== 8'h3C || v_cyc[0] != fall + 1 + LAT) begin
                errors++; $display("FAIL clr_resume: got data %h lat %0d want 3c lat %0d", v_data[0], v_cyc[0] - fall - 1, LAT);
            end
        end
    endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
    task automatic test_parity();
        int fall;
        clear_q();
        send_frame(8'h07, 1'b0, 1'b1, fall);
        idle(CPB);
        send_frame(8'h07, 1'b1, 1'b1, fall);
        idle(2 * CPB);
        last_good = 8'h07;
        checks++;
        if (v_cyc.size() != 2) begin errors++; $display("FAIL parity_count: got %0d want 2", v_cyc.size()); end
        else begin
            checks++;
            if (v_perr[0] !== 1'b1 || v_data[0] !== 8'h07) begin
                errors++; $display("FAIL parity_bad: got perr %b data %h want 1 07", v_perr[0], v_data[0]);
            end
            checks++;
            if (v_perr[1] !== 1'b0 || v_data[1] !== 8'h07) begin
                errors++; $display("FAIL parity_good: got perr %b data %h want 0 07", v_perr[1], v_data[1]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int            e_cyc[$];
        logic [DB-1:0] e_data[$];
        bit            e_perr[$];
        int            ef_cyc[$];
        logic [DB-1:0] ef_data[$];
        clear_q();
        for (int n = 0; n < 24; n++) begin
            logic [DB-1:0] d;
            logic          stop, pbit;
            int            gap, fall;
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pbit = 1'(PAR ? $urandom_range(0, 1) : 0);
            gap  = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            send_frame(d, pbit, stop, fall);
            if (stop) begin
                e_cyc.push_back(fall + 1 + LAT);
                e_data.push_back(d);
                e_perr.push_back(PAR && (pbit != ^d));
                last_good = d;
            end else begin
                ef_cyc.push_back(fall + 1 + LAT);
                ef_data.push_back(last_good);
            end
            if (gap > 0) idle(gap * CPB);
        end
        idle(2 * CPB);
        checks++;
        if (v_cyc.size() != e_cyc.size()) begin
            errors++; $display("FAIL rand_valid_count: got %0d want %0d", v_cyc.size(), e_cyc.size());
        end else begin
            for (int i = 0; i < e_cyc.size(); i++) begin
                checks++;
                if (v_cyc[i] != e_cyc[i] || v_data[i] !== e_data[i] || v_perr[i] !== e_perr[i]) begin
                    errors++;
                    $display("FAIL rand_valid[%0d]: got cyc %0d data %h perr %b want cyc %0d data %h perr %b",
                             i, v_cyc[i], v_data[i], v_perr[i], e_cyc[i], e_data[i], e_perr[i]);
                end
            end
        end
        checks++;
        if (f_cyc.size() != ef_cyc.size()) begin
            errors++; $display("FAIL rand_ferr_count: got %0d want %0d", f_cyc.size(), ef_cyc.size());
        end else begin
            for (int i = 0; i < ef_cyc.size(); i++) begin
                checks++;
                if (f_cyc[i] != ef_cyc[i] || f_data[i] !== ef_data[i]) begin
                    errors++;
                    $display("FAIL rand_ferr[%0d]: got cyc %0d data %h want cyc %0d data %h",
                             i, f_cyc[i], f_data[i], ef_cyc[i], ef_data[i]);
                end
            end
        end
    endtask

    initial begin
        clr       = 1'b1;
        bus.sdi   = 1'b1;
        last_good = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_clr_abort();
`ifdef SERIAL_FRAME_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
